// File: rtl/mem_access_unit_if.sv
// Request, response and data_memory signal bundle for mem_access_unit.
// The master side is the execute/writeback/memory environment; the slave side is the unit.
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_W   = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [RD_W-1:0]   rsp_rd;
  logic              rsp_is_load;
  logic              rsp_fault;

  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_rd, rsp_ready, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_is_load, rsp_fault,
           dm_we, dm_addr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_rd, rsp_ready, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_is_load, rsp_fault,
           dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: IDLE -> ACCESS (one data_memory cycle) -> RESP.
// Define LSU_BOUNDS_CHECK_EN to fault out-of-range addresses instead of wrapping them.
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 512,
  parameter int RD_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((1 << IDX_W) - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            lat_we;
  logic            lat_fault;
  logic [RD_W-1:0] lat_rd;
  logic            accept;
  logic            req_fault;

  // Gating with rst_n keeps the handshake and the write strobe quiet while reset is held.
  assign bus.req_ready = rst_n & ((state == IDLE) | ((state == RESP) & bus.rsp_ready));
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.dm_we     = rst_n & (state == ACCESS) & lat_we & ~lat_fault;

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_fault = |(bus.req_addr & ~ADDR_MASK);
`else
  assign req_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat_we          <= 1'b0;
      lat_fault       <= 1'b0;
      lat_rd          <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_W{1'b0}};
      bus.rsp_rd      <= '0;
      bus.rsp_is_load <= 1'b0;
      bus.rsp_fault   <= 1'b0;
      bus.dm_addr     <= '0;
      bus.dm_wdata    <= '0;
      ld_count        <= 16'h0000;
      st_count        <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          state <= accept ? ACCESS : IDLE;
        end
        ACCESS: begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rd      <= lat_rd;
          bus.rsp_is_load <= ~lat_we;
          bus.rsp_fault   <= lat_fault;
          bus.rsp_rdata   <= (lat_we | lat_fault) ? {DATA_W{1'b0}} : bus.dm_rdata;
          if (!lat_fault) begin
            if (lat_we && (st_count != 16'hFFFF)) st_count <= st_count + 16'd1;
            if (!lat_we && (ld_count != 16'hFFFF)) ld_count <= ld_count + 16'd1;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= accept ? ACCESS : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // dm_addr/dm_wdata are loaded at accept so they are already valid throughout ACCESS.
      if (accept) begin
        lat_we       <= bus.req_we;
        lat_fault    <= req_fault;
        lat_rd       <= bus.req_rd;
        bus.dm_addr  <= bus.req_addr & ADDR_MASK;
        bus.dm_wdata <= bus.req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand sequences and a random run
// against a word-array reference model of data_memory and the counters.
module tb_mem_access_unit;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 512;
  localparam int RD_W   = 3;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  rd;
    logic [15:0] expRdata;
    logic        expFault;
  } vec_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic [2:0]  rd;
    logic        isLoad;
    logic        fault;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memLoad = 1'b1;
  logic [15:0] ld_count, st_count;
  logic [15:0] mem    [DEPTH];
  logic [15:0] refMem [DEPTH];
  logic [15:0] expLd = 16'h0, expSt = 16'h0;
  rsp_t        expQ[$];
  vec_t        vecs[8];
  int          checks = 0;
  int          failures = 0;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .RD_W(RD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ld_count (ld_count),
    .st_count (st_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] initWord(int i);
    return 16'(i) ^ 16'hA000;
  endfunction

  // data_memory: combinational read, write on the rising edge.
  assign bus.dm_rdata = mem[bus.dm_addr[8:0]];
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initWord(i);
    end else if (bus.dm_we) begin
      mem[bus.dm_addr[8:0]] <= bus.dm_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=event expected=no event", name);
  endtask

  function automatic rsp_t actRsp();
    return {bus.rsp_rdata, bus.rsp_rd, bus.rsp_is_load, bus.rsp_fault};
  endfunction

  // Reference model: what an accepted request must return, and its effect on memory/counters.
  task automatic modelAccept(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [2:0] rd, output rsp_t r);
    bit fault = BOUNDS && (int'(addr) >= DEPTH);
    int idx = int'(addr) % DEPTH;
    r.rd     = rd;
    r.isLoad = !we;
    r.fault  = fault;
    r.rdata  = (we || fault) ? 16'h0000 : refMem[idx];
    if (!fault) begin
      if (we) begin
        refMem[idx] = wdata;
        if (expSt != 16'hFFFF) expSt = expSt + 16'd1;
      end else if (expLd != 16'hFFFF) begin
        expLd = expLd + 16'd1;
      end
    end
  endtask

  task automatic scoreCycle();
    rsp_t r;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (expQ.size() > 0) checkOutput("rsp_payload", 64'(actRsp()), 64'(expQ.pop_front()));
      else reportFail("unexpected_rsp");
    end
    if (bus.req_valid && bus.req_ready) begin
      modelAccept(bus.req_we, bus.req_addr, bus.req_wdata, bus.req_rd, r);
      expQ.push_back(r);
    end
  endtask

  // One full transaction from the table, with ACCESS-cycle and latency checks.
  task automatic applyStimulus(input vec_t v);
    int   guard = 0;
    rsp_t dummy;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_rd    = v.rd;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("vec_accept", 64'(bus.req_ready), 64'(1));
    modelAccept(v.we, v.addr, v.wdata, v.rd, dummy);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("vec_access_cycle", 64'({bus.dm_we, bus.dm_addr, bus.dm_wdata, bus.rsp_valid}),
                64'({v.we & ~v.expFault, v.addr & 16'h01FF, v.wdata, 1'b0}));
    @(negedge clk);
    checkOutput("vec_latency", 64'({bus.rsp_valid, bus.dm_we}), 64'({1'b1, 1'b0}));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rsp_t expR;
    int   acceptCyc[4];
    int   nAcc, nRsp, cyc;
    logic [15:0] ldBase;

    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    vecs[0] = '{1'b1, 16'h00A5, 16'hBEEF, 3'd0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h00A5, 16'h0000, 3'd5, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0010, 16'h1234, 3'd2, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0010, 16'h0000, 3'd7, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 16'h0200, 16'hCAFE, 3'd4, 16'h0000, BOUNDS};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 3'd1, BOUNDS ? initWord(0) : 16'hCAFE, 1'b0};
    vecs[6] = '{1'b0, 16'h0200, 16'h0000, 3'd3, BOUNDS ? 16'h0000 : 16'hCAFE, BOUNDS};
    vecs[7] = '{1'b0, 16'h01FF, 16'h0000, 3'd6, initWord(511), 1'b0};

    // Reset held with a request pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h00A5;
    bus.req_wdata = 16'h5555; bus.req_rd = 3'd1; bus.rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs", 64'({bus.req_ready, bus.dm_we, bus.rsp_valid, bus.rsp_rdata,
                  bus.rsp_rd, bus.rsp_is_load, bus.rsp_fault, bus.dm_addr, bus.dm_wdata}), 64'(0));
      checkOutput("reset_counters", 64'({ld_count, st_count}), 64'(0));
    end
    @(posedge clk); #1;
    memLoad = 1'b0; bus.req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k]);
      checkOutput("vec_rsp", 64'(actRsp()),
                  64'({vecs[k].expRdata, vecs[k].rd, ~vecs[k].we, vecs[k].expFault}));
      checkOutput("vec_counters", 64'({ld_count, st_count}), 64'({expLd, expSt}));
      @(posedge clk); #1;
    end

    $display("[TB] backpressure");
    bus.req_we = 1'b0; bus.req_addr = 16'h0010; bus.req_rd = 3'd2; bus.req_wdata = 16'h0000;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_accept", 64'(bus.req_ready), 64'(1));
    modelAccept(1'b0, 16'h0010, 16'h0000, 3'd2, expR);
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_addr = 16'h0011; bus.req_wdata = 16'h7777; bus.req_rd = 3'd4;
    @(negedge clk);
    checkOutput("bp_access_not_ready", 64'(bus.req_ready), 64'(0));
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bp_hold_rsp", 64'({bus.rsp_valid, actRsp()}), 64'({1'b1, expR}));
      checkOutput("bp_hold_quiet", 64'({bus.req_ready, bus.dm_we}), 64'(0));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_dual_handshake", 64'({bus.req_ready, bus.rsp_valid}), 64'({1'b1, 1'b1}));
    modelAccept(1'b1, 16'h0011, 16'h7777, 3'd4, expR);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_access", 64'({bus.dm_we, bus.dm_addr, bus.dm_wdata, bus.rsp_valid}),
                64'({1'b1, 16'h0011, 16'h7777, 1'b0}));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_next_rsp", 64'({bus.rsp_valid, actRsp()}), 64'({1'b1, expR}));
    @(posedge clk); #1;

    $display("[TB] streaming loads");
    ldBase = expLd; nAcc = 0; nRsp = 0; cyc = 0;
    foreach (acceptCyc[i]) acceptCyc[i] = 0;
    bus.rsp_ready = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010; bus.req_rd = 3'd0;
    bus.req_wdata = 16'h0000; bus.req_valid = 1'b1;
    while ((nAcc < 4 || nRsp < 4) && cyc < 40) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) nRsp++;
      if (bus.req_valid && bus.req_ready) begin
        acceptCyc[nAcc] = cyc;
        nAcc++;
      end
      scoreCycle();
      @(posedge clk); #1;
      cyc++;
      bus.req_valid = (nAcc < 4);
      bus.req_addr  = 16'h0010 + 16'(nAcc);
      bus.req_rd    = 3'(nAcc + 1);
    end
    checkOutput("stream_counts", 64'({nAcc, nRsp}), 64'({32'd4, 32'd4}));
    for (int i = 1; i < 4; i++)
      checkOutput("stream_gap", 64'(acceptCyc[i] - acceptCyc[i-1]), 64'(2));
    checkOutput("stream_ld_count", 64'(ld_count), 64'(ldBase + 16'd4));

    $display("[TB] reset during ACCESS of a store");
    bus.req_we = 1'b1; bus.req_addr = 16'h00A5; bus.req_wdata = 16'h1111; bus.req_rd = 3'd0;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_accept", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("midrst_we_before", 64'(bus.dm_we), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_we_after", 64'(bus.dm_we), 64'(0));
    repeat (2) @(negedge clk);
    checkOutput("midrst_mem_kept", 64'(mem[9'h0A5]), 64'(refMem[9'h0A5]));
    checkOutput("midrst_outputs", 64'({bus.rsp_valid, bus.req_ready, ld_count, st_count}), 64'(0));
    expLd = 16'h0; expSt = 16'h0;
    expQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int c = 0; c < 800; c++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = ($urandom_range(0, 7) == 0) ? 16'(32'h200 + $urandom_range(0, 32'hFDFF))
                                                  : 16'(32'h40 + $urandom_range(0, 15));
      bus.req_wdata = 16'($urandom);
      bus.req_rd    = 3'($urandom_range(0, 7));
      @(negedge clk);
      scoreCycle();
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      scoreCycle();
      @(posedge clk); #1;
    end
    checkOutput("rand_drained", 64'(expQ.size()), 64'(0));
    checkOutput("rand_counters", 64'({ld_count, st_count}), 64'({expLd, expSt}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
